// File: rtl/mem_prefetch_fifo.sv
// Deep FIFO stored in an external 2-port SRAM, fronted by a small prefetch
// cache that hides the SRAM read latency.
//
// Ports:
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_wr_vld/i_wdata/o_wr_rdy   write stream (accepted when vld & rdy)
//   o_rd_vld/o_rdata/i_rd_rdy   read stream from the registered cache head
//   o_rd_cerr/o_rd_uerr         ECC flags travelling with the head word
//   o_empty/o_full/o_fill_cnt   occupancy, counting SRAM and in-flight words
//   o_overflow/i_ovf_clr        sticky write-while-full flag and its clear
//   i_alful_th/o_alful          almost-full: fill_cnt >= threshold
//   i_alempt_th/o_alempt        almost-empty: fill_cnt <= threshold
//   o_mem_wr/o_mem_waddr/o_mem_wdata            SRAM write port
//   o_mem_rd/o_mem_raddr                        SRAM read port
//   i_mem_rdata/i_mem_cerr/i_mem_uerr           SRAM read return
module mem_prefetch_fifo #(
  parameter int DW         = 32,
  parameter int MEM_DEP    = 256,
  parameter int MEM_RD_LAT = 2,
  parameter int CACHE_DEP  = 4,
  parameter int FIFO_DEP   = CACHE_DEP + MEM_DEP,
  parameter int FIFO_CW    = $clog2(FIFO_DEP + 1),
  parameter int MEM_AW     = $clog2(MEM_DEP)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_vld,
  input  logic [DW-1:0]      i_wdata,
  output logic               o_wr_rdy,
  output logic               o_rd_vld,
  output logic [DW-1:0]      o_rdata,
  output logic               o_rd_cerr,
  output logic               o_rd_uerr,
  input  logic               i_rd_rdy,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_overflow,
  input  logic               i_ovf_clr,
  output logic [FIFO_CW-1:0] o_fill_cnt,
  input  logic [FIFO_CW-1:0] i_alful_th,
  input  logic [FIFO_CW-1:0] i_alempt_th,
  output logic               o_alful,
  output logic               o_alempt,
  output logic               o_mem_wr,
  output logic [MEM_AW-1:0]  o_mem_waddr,
  output logic [DW-1:0]      o_mem_wdata,
  output logic               o_mem_rd,
  output logic [MEM_AW-1:0]  o_mem_raddr,
  input  logic [DW-1:0]      i_mem_rdata,
  input  logic               i_mem_cerr,
  input  logic               i_mem_uerr
);

  localparam int CAW = $clog2(CACHE_DEP);
  localparam int CCW = $clog2(CACHE_DEP + 1);
  localparam int MCW = $clog2(MEM_DEP + 1);

  if (CACHE_DEP < MEM_RD_LAT + 2) begin : g_cfg_err
    $error("mem_prefetch_fifo: CACHE_DEP must be >= MEM_RD_LAT+2");
  end

  logic [FIFO_CW-1:0]    fill_cnt;
  logic [MCW-1:0]        mem_cnt;
  logic [CCW-1:0]        cache_cnt;
  logic [CCW-1:0]        inflight;
  logic [MEM_AW-1:0]     mem_wr_ptr;
  logic [MEM_AW-1:0]     mem_rd_ptr;
  logic [CAW-1:0]        head;
  logic [CAW-1:0]        tail;
  logic [MEM_RD_LAT-1:0] pipe_vld;
  logic [CAW-1:0]        pipe_slot [MEM_RD_LAT];
  logic                  ovf;

  logic [DW-1:0] c_data [CACHE_DEP];
  logic          c_cerr [CACHE_DEP];
  logic          c_uerr [CACHE_DEP];

  logic           full;
  logic           wr_acc;
  logic           pop;
  logic [CCW:0]   occ;
  logic           has_free;
  logic           byp;
  logic           mem_wr;
  logic           mem_rd;
  logic           ret;
  logic [CAW-1:0] ret_slot;

  // Cache slots are reserved in order at the tail, whether by a bypass
  // write or by an SRAM read; returns come back in issue order, so the
  // filled entries are always a contiguous run starting at head.
  always_comb begin
    full     = fill_cnt == FIFO_CW'(FIFO_DEP);
    wr_acc   = i_wr_vld & ~full;
    pop      = (cache_cnt != '0) & i_rd_rdy;
    occ      = {1'b0, cache_cnt} + {1'b0, inflight};
    has_free = occ < (CCW+1)'(CACHE_DEP);
    byp      = wr_acc & (mem_cnt == '0) & (inflight == '0) & has_free;
    mem_wr   = wr_acc & ~byp;
    mem_rd   = (mem_cnt != '0) & has_free;
    ret      = pipe_vld[MEM_RD_LAT-1];
    ret_slot = pipe_slot[MEM_RD_LAT-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fill_cnt   <= '0;
      mem_cnt    <= '0;
      cache_cnt  <= '0;
      inflight   <= '0;
      mem_wr_ptr <= '0;
      mem_rd_ptr <= '0;
      head       <= '0;
      tail       <= '0;
      pipe_vld   <= '0;
      ovf        <= 1'b0;
      for (int i = 0; i < MEM_RD_LAT; i++) begin
        pipe_slot[i] <= '0;
      end
    end else begin
      unique case ({wr_acc, pop})
        2'b10:   fill_cnt <= fill_cnt + 1'b1;
        2'b01:   fill_cnt <= fill_cnt - 1'b1;
        default: fill_cnt <= fill_cnt;
      endcase
      unique case ({mem_wr, mem_rd})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
      unique case ({byp | ret, pop})
        2'b10:   cache_cnt <= cache_cnt + 1'b1;
        2'b01:   cache_cnt <= cache_cnt - 1'b1;
        default: cache_cnt <= cache_cnt;
      endcase
      unique case ({mem_rd, ret})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (mem_wr) begin
        mem_wr_ptr <= (mem_wr_ptr == MEM_AW'(MEM_DEP - 1)) ?
                      '0 : mem_wr_ptr + 1'b1;
      end
      if (mem_rd) begin
        mem_rd_ptr <= (mem_rd_ptr == MEM_AW'(MEM_DEP - 1)) ?
                      '0 : mem_rd_ptr + 1'b1;
      end
      if (byp | mem_rd) begin
        tail <= (tail == CAW'(CACHE_DEP - 1)) ? '0 : tail + 1'b1;
      end
      if (pop) begin
        head <= (head == CAW'(CACHE_DEP - 1)) ? '0 : head + 1'b1;
      end
      pipe_vld[0]  <= mem_rd;
      pipe_slot[0] <= tail;
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_slot[i] <= pipe_slot[i-1];
      end
      if (i_wr_vld & full) begin
        ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Bypass needs inflight==0, so it never shares a cycle with a return.
  always_ff @(posedge i_clk) begin
    if (byp) begin
      c_data[tail] <= i_wdata;
      c_cerr[tail] <= 1'b0;
      c_uerr[tail] <= 1'b0;
    end
    if (ret & ~i_rst) begin
      c_data[ret_slot] <= i_mem_rdata;
      c_cerr[ret_slot] <= i_mem_cerr;
      c_uerr[ret_slot] <= i_mem_uerr;
    end
  end

  // With the SRAM completely full, wr_ptr equals rd_ptr, and a write
  // accepted then lands on the word being read in the same cycle; the
  // SRAM must return the old contents in that case.
  assign o_mem_wr    = mem_wr;
  assign o_mem_waddr = mem_wr_ptr;
  assign o_mem_wdata = i_wdata;
  assign o_mem_rd    = mem_rd;
  assign o_mem_raddr = mem_rd_ptr;

  assign o_rd_vld   = cache_cnt != '0;
  assign o_rdata    = c_data[head];
  assign o_rd_cerr  = c_cerr[head];
  assign o_rd_uerr  = c_uerr[head];
  assign o_wr_rdy   = ~full;
  assign o_full     = full;
  assign o_empty    = fill_cnt == '0;
  assign o_overflow = ovf;
  assign o_fill_cnt = fill_cnt;
  assign o_alful    = fill_cnt >= i_alful_th;
  assign o_alempt   = fill_cnt <= i_alempt_th;

endmodule
